// File: rtl/ila_trigger_sequencer_if.sv
// Probe, trigger and register-write bundle between the debug fabric and the
// ILA trigger sequencer. The master drives probes and configuration writes; the
// slave (the sequencer) drives the ILA-facing outputs.
interface ila_trigger_sequencer_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_trig;
  logic                      cfg_we;
  logic [1:0]                cfg_addr;
  logic [CNT_W-1:0]          cfg_wdata;
  logic [DATA_W-1:0]         ila_data;
  logic                      ila_trig0;
  logic                      ila_trig1;
  logic                      ila_trig2;
  logic                      busy;
  logic                      done;

  modport master (
    output src_data, src_trig, cfg_we, cfg_addr, cfg_wdata,
    input  ila_data, ila_trig0, ila_trig1, ila_trig2, busy, done
  );

  modport slave (
    input  src_data, src_trig, cfg_we, cfg_addr, cfg_wdata,
    output ila_data, ila_trig0, ila_trig1, ila_trig2, busy, done
  );
endinterface

// File: rtl/ila_trigger_sequencer.sv
// Probe arbiter and occurrence-count trigger sequencer in front of the ILA.
// One probe group is registered onto the ILA data bus together with its raw
// trigger; an FSM counts qualifying trigger cycles, pulses a qualified trigger
// and holds a post-trigger capture window.
module ila_trigger_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    reset,
  ila_trigger_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WINDOW, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  occ_target_q, occ_target_d;
  logic [CNT_W-1:0]  win_len_q, win_len_d;
  logic [CNT_W-1:0]  occ_cnt_q, occ_cnt_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              trig_q, trig_d;
  logic              trig1_q, trig1_d;
  logic              trig2_q, trig2_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ctl_wr, arm, abort, cfg_open;
  logic [CNT_W-1:0]  target_m1;

  assign ctl_wr    = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign arm       = ctl_wr && bus.cfg_wdata[8];
  assign abort     = ctl_wr && bus.cfg_wdata[9];
  assign cfg_open  = (state_q == S_IDLE) || (state_q == S_DONE);
  // A target of 0 behaves like 1, so the last-occurrence compare is target-1.
  assign target_m1 = (occ_target_q == '0) ? '0 : occ_target_q - CNT_W'(1);

  // Probe mux and configuration registers; config only changes when not busy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    data_d       = '0;
    trig_d       = 1'b0;
    sel_d        = sel_q;
    occ_target_d = occ_target_q;
    win_len_d    = win_len_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_q == 2'(k)) begin
        data_d = bus.src_data[k*DATA_W +: DATA_W];
        trig_d = bus.src_trig[k];
      end
    end
    if (bus.cfg_we && cfg_open) begin
      case (bus.cfg_addr)
        2'd0:    sel_d = (int'(bus.cfg_wdata[1:0]) < NUM_SRC) ? bus.cfg_wdata[1:0] : 2'd0;
        2'd1:    occ_target_d = bus.cfg_wdata;
        2'd2:    win_len_d    = bus.cfg_wdata;
        default: ;
      endcase
    end
  end

  // Trigger FSM next state, counters and registered ILA trigger/status outputs.
  always_comb begin
    state_d   = state_q;
    occ_cnt_d = occ_cnt_q;
    win_cnt_d = win_cnt_q;
    trig1_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d   = S_ARMED;
          occ_cnt_d = '0;
          win_cnt_d = '0;
        end
      end
      S_ARMED: begin
        if (trig_q) begin
          if (occ_cnt_q == target_m1) begin
            trig1_d = 1'b1;
            if (win_len_q != '0) begin
              state_d   = S_WINDOW;
              win_cnt_d = CNT_W'(1);
            end else begin
              state_d = S_DONE;
            end
          end else if (occ_cnt_q != '1) begin
            occ_cnt_d = occ_cnt_q + CNT_W'(1);
          end
        end
      end
      S_WINDOW: begin
        if (win_cnt_q == win_len_q) begin
          state_d = S_DONE;
        end else if (win_cnt_q != '1) begin
          win_cnt_d = win_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including an arm in the same write.
    if (abort) begin
      state_d = S_IDLE;
      trig1_d = 1'b0;
    end
    trig2_d = (state_d == S_WINDOW);
    busy_d  = (state_d == S_ARMED) || (state_d == S_WINDOW);
    done_d  = (state_d == S_DONE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath, configuration, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= 2'd0;
      occ_target_q <= CNT_W'(1);
      win_len_q    <= '0;
      occ_cnt_q    <= '0;
      win_cnt_q    <= '0;
      data_q       <= '0;
      trig_q       <= 1'b0;
      trig1_q      <= 1'b0;
      trig2_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      occ_target_q <= occ_target_d;
      win_len_q    <= win_len_d;
      occ_cnt_q    <= occ_cnt_d;
      win_cnt_q    <= win_cnt_d;
      data_q       <= data_d;
      trig_q       <= trig_d;
      trig1_q      <= trig1_d;
      trig2_q      <= trig2_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.ila_data  = data_q;
  assign bus.ila_trig0 = trig_q;
  assign bus.ila_trig1 = trig1_q;
  assign bus.ila_trig2 = trig2_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
